// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_pkg
//  Purpose : Shared definitions for the 8-bit ALU and its multi-byte
//            sequencer: ALU op codes and the sequencer state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

   // ALU operation codes, shared by the ALU and the sequencer
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   // Sequencer control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/alu8.sv
`default_nettype none
// ============================================================================
//  Module  : alu8
//  Purpose : Combinational 8-bit ALU: add, subtract (with borrow), OR, AND.
//  Ports   : a_i, b_i  in  8  byte operands
//            op_i      in  2  operation (OP_ADD/OP_SUB/OP_OR/OP_AND)
//            cin_i     in  1  carry-in (add) / borrow-in (subtract)
//            y_o       out 8  byte result
//            cout_o    out 1  carry-out (add) / borrow-out (subtract), 0 else
//  Rev     : 1.0  initial release
// ============================================================================
module alu8
   import alu_pkg::*;
(
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic [1:0] op_i,
   input  logic       cin_i,
   output logic [7:0] y_o,
   output logic       cout_o
);

   logic [8:0] w_sum;
   logic [8:0] w_diff;

   // 9-bit arithmetic: bit 8 is carry for add; for subtract a negative
   // result wraps so bit 8 becomes the borrow.
   assign w_sum  = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};
   assign w_diff = {1'b0, a_i} - {1'b0, b_i} - {8'd0, cin_i};

   always_comb begin
      y_o    = 8'd0;
      cout_o = 1'b0;
      case (op_i)
         OP_ADD: begin
            y_o    = w_sum[7:0];
            cout_o = w_sum[8];
         end
         OP_SUB: begin
            y_o    = w_diff[7:0];
            cout_o = w_diff[8];
         end
         OP_OR:   y_o = a_i | b_i;
         default: y_o = a_i & b_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_byte_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : alu_byte_sequencer
//  Purpose : Drives an external 8-bit ALU one byte per cycle (LSB first) to
//            perform NBYTES-wide add/subtract/OR/AND, chaining carry/borrow
//            between bytes and assembling the wide result.
//  Ports   : clk, rst          clock, synchronous active-high reset
//            start_i           request, sampled only in IDLE
//            op_code_i [2]     operation, latched with start
//            opa_i, opb_i [W]  wide operands, latched with start
//            c_in_i            initial carry/borrow, latched with start
//            busy_o            high while bytes are being processed
//            done_o            one-cycle completion pulse
//            result_o [W]      wide result, held until overwritten
//            c_out_o           final carry/borrow, held with result
//            alu_a_o, alu_b_o  byte operands to the ALU
//            alu_op_o, alu_cin_o  op code and carry/borrow to the ALU
//            alu_y_i, alu_cout_i  byte result and carry/borrow from the ALU
//  Rev     : 1.0  initial release
// ============================================================================
module alu_byte_sequencer
   import alu_pkg::*;
#(
   parameter int NBYTES = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [1:0]            op_code_i,
   input  logic [8*NBYTES-1:0]   opa_i,
   input  logic [8*NBYTES-1:0]   opb_i,
   input  logic                  c_in_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [8*NBYTES-1:0]   result_o,
   output logic                  c_out_o,
   output logic [7:0]            alu_a_o,
   output logic [7:0]            alu_b_o,
   output logic [1:0]            alu_op_o,
   output logic                  alu_cin_o,
   input  logic [7:0]            alu_y_i,
   input  logic                  alu_cout_i
);

   localparam int            W      = 8 * NBYTES;
   localparam int            KW     = $clog2(NBYTES);
   localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

   seq_state_e     state_q,  state_d;
   logic [KW-1:0]  k_q,      k_d;
   logic [W-1:0]   opa_q,    opa_d;
   logic [W-1:0]   opb_q,    opb_d;
   logic [1:0]     op_q,     op_d;
   logic           carry_q,  carry_d;
   logic [W-1:0]   result_q, result_d;
   logic           c_out_q,  c_out_d;

   logic [7:0]     a_byte;
   logic [7:0]     b_byte;

   // Current byte of each latched operand, selected by k
   always_comb begin
      a_byte = 8'd0;
      b_byte = 8'd0;
      for (int b = 0; b < NBYTES; b++) begin
         if (k_q == KW'(b)) begin
            a_byte = opa_q[8*b +: 8];
            b_byte = opb_q[8*b +: 8];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         k_q      <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         op_q     <= 2'b00;
         carry_q  <= 1'b0;
         result_q <= '0;
         c_out_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      op_d      = op_q;
      carry_d   = carry_q;
      result_d  = result_q;
      c_out_d   = c_out_q;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      alu_a_o   = 8'd0;
      alu_b_o   = 8'd0;
      alu_op_o  = 2'b00;
      alu_cin_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               k_d     = '0;
               opa_d   = opa_i;
               opb_d   = opb_i;
               op_d    = op_code_i;
               // The chain register doubles as the initial carry for byte 0,
               // so alu_cin is always taken from it during RUN.
               carry_d = c_in_i;
            end
         end

         ST_RUN: begin
            busy_o    = 1'b1;
            alu_a_o   = a_byte;
            alu_b_o   = b_byte;
            alu_op_o  = op_q;
            alu_cin_o = carry_q;
            carry_d   = alu_cout_i;
            for (int b = 0; b < NBYTES; b++) begin
               if (k_q == KW'(b)) begin
                  result_d[8*b +: 8] = alu_y_i;
               end
            end
            if (k_q == K_LAST) begin
               c_out_d = alu_cout_i;
               state_d = ST_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign result_o = result_q;
   assign c_out_o  = c_out_q;

endmodule
`default_nettype wire
